bus_cycle_sequencer: RTL
========================

Name: bus_cycle_sequencer

Overview:
Arbiter and sequencer for the single multiplexed external bus of the 6502 core. Instruction fetch, operand load/store and vector fetch all share that bus. The block grants one requester at a time and sequences the bus cycle as address-high, address-low, then a data phase with wait-state and timeout handling. It sits between the core's internal requesters and the uo_out/uio pins.

Parameters:
NREQ, 3, number of requesters; index 0 has the highest fixed priority.
WAIT_MAX, 15, maximum data-phase cycles with rdy_in low before abort.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst_n  input  1  reset.
req  input  NREQ  per-requester request level; held high until the matching done.
addr_in  input  16*NREQ  flattened addresses; requester i uses bits [16i+15:16i].
we_in  input  NREQ  1 = write, 0 = read, per requester.
wdata_in  input  8*NREQ  flattened write data.
rdy_in  input  1  external ready; low inserts wait states in DATA.
db_in  input  8  external data bus input.
gnt  output  NREQ  one-hot grant, valid from ADDR_HI through DATA.
done  output  NREQ  one-cycle completion pulse for the granted requester.
err  output  1  one-cycle pulse coincident with done on timeout.
rdata  output  8  captured read data.
ab_out  output  8  multiplexed address byte.
ab_phase  output  1  1 = ab_out carries A[15:8], 0 = A[7:0].
db_out  output  8  write data driven to the pins.
db_oe  output  1  pin output enable.
rw  output  1  1 = read, 0 = write.

Behaviour:
- Reset: rst_n is synchronous and active-low. It is sampled on posedge clk; while low the block holds reset.
- Reset values: state IDLE, gnt 0, done 0, err 0, rdata 0x00, ab_out 0x00, ab_phase 0, db_out 0x00, db_oe 0, rw 1, wait counter 0, RR pointer 0.
- Reset mid-transfer aborts the transfer; no done or err is issued.
- IDLE: if any req bit is high, arbitrate and latch the winner's index, addr, we and wdata into registers, set gnt, then go to ADDR_HI. Otherwise stay in IDLE with rw=1 and db_oe=0.
- ADDR_HI (1 cycle): ab_out = A[15:8], ab_phase = 1, rw = 1. Go to ADDR_LO.
- ADDR_LO (1 cycle): ab_out = A[7:0], ab_phase = 0. rw = ~we is driven from this cycle onward. Go to DATA.
- DATA:
  - Write: db_oe = 1, db_out = latched wdata.
  - rdy_in = 1: a read captures db_in into rdata; done[g] pulses; go to IDLE with gnt cleared and the wait counter cleared.
  - rdy_in = 0: increment the wait counter. When the counter reaches WAIT_MAX, pulse done[g] and err, leave rdata unchanged, go to IDLE.
- All outputs are registered. done, err, the rdata update and the gnt clear all become visible in the first IDLE cycle.
- Latency: a zero-wait transfer takes 4 cycles from req sampled to done (IDLE, HI, LO, DATA). Back-to-back requests repeat with no bubble beyond the IDLE arbitration cycle.
- req, addr_in, we_in and wdata_in changes after the latch are ignored until done. Deasserting req mid-transfer does not cancel the transfer.
- A requester whose req is still high in the IDLE cycle that shows its done is eligible for re-arbitration in that same cycle.
- Fixed priority: the lowest index wins.

Optional Feature:
Macro BUS_RR_EN.
- Defined: round-robin arbitration. The pointer advances to last-granted+1 modulo NREQ, and the search starts at the pointer; after reset the pointer is 0.
- Undefined: fixed priority only; no pointer logic is synthesised.

Test Plan:
- Read: req[1], addr 0x12AB, we 0, rdy_in 1, db_in 0x5C -> ab_out 0x12 with ab_phase 1, then 0xAB with ab_phase 0; rw 1; done[1] and rdata 0x5C 4 cycles after req.
- Write: req[2], addr 0x01FF, wdata 0xA7 -> rw 0 from ADDR_LO; db_oe 1 with db_out 0xA7 in DATA; done[2] pulses; db_oe 0 in IDLE.
- Simultaneous req = 3'b111, held -> grants in order 0, 0, ... without BUS_RR_EN; order 0, 1, 2 with BUS_RR_EN.
- rdy_in low for 3 DATA cycles on a read of 0x33 -> DATA lasts 4 cycles; done and rdata 0x33 after 7 cycles total; err 0.
- rdy_in held low -> after WAIT_MAX = 15 DATA cycles, done[g] and err pulse together; rdata unchanged; next request is served normally.
- rst_n low during ADDR_LO of a write -> next cycle shows all reset values (rw 1, db_oe 0, gnt 0); no done pulse.

Source files
------------

// File: rtl/bus_cycle_sequencer.sv
// Arbiter and cycle sequencer for the shared multiplexed external bus: ADDR_HI, ADDR_LO, DATA.
// Optional macro BUS_RR_EN selects round-robin arbitration; undefined gives fixed priority.
module bus_cycle_sequencer #(
  parameter int NREQ     = 3,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   addr_in,
  input  logic [NREQ-1:0]      we_in,
  input  logic [8*NREQ-1:0]    wdata_in,
  input  logic                 rdy_in,
  input  logic [7:0]           db_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic [7:0]           ab_out,
  output logic                 ab_phase,
  output logic [7:0]           db_out,
  output logic                 db_oe,
  output logic                 rw
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester raises req and may drop it at any time after its grant;
  // done (with err on timeout) is a one-cycle pulse in the first IDLE cycle after DATA.
  typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, DATA} state_t;

  state_t            state;
  logic [IW-1:0]     gidx;
  logic [15:0]       addr_q;
  logic              we_q;
  logic [7:0]        wdata_q;
  logic [WAIT_W-1:0] wcnt;

  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [15:0]       sel_addr;
  logic              sel_we;
  logic [7:0]        sel_wdata;

`ifdef BUS_RR_EN
  logic [IW-1:0] ptr;
  int            scan;

  // Search starts at the pointer and wraps; the first live request wins.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    scan      = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(ptr) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!win_vld && req[scan]) begin
        win_vld   = 1'b1;
        win_idx   = IW'(scan);
        sel_addr  = addr_in[16*scan +: 16];
        sel_we    = we_in[scan];
        sel_wdata = wdata_in[8*scan +: 8];
      end
    end
  end
`else
  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_vld   = 1'b1;
        win_idx   = IW'(k);
        sel_addr  = addr_in[16*k +: 16];
        sel_we    = we_in[k];
        sel_wdata = wdata_in[8*k +: 8];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gidx     <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wcnt     <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      ab_out   <= '0;
      ab_phase <= 1'b0;
      db_out   <= '0;
      db_oe    <= 1'b0;
      rw       <= 1'b1;
`ifdef BUS_RR_EN
      ptr      <= '0;
`endif
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          rw    <= 1'b1;
          db_oe <= 1'b0;
          if (win_vld) begin
            gidx     <= win_idx;
            addr_q   <= sel_addr;
            we_q     <= sel_we;
            wdata_q  <= sel_wdata;
            gnt      <= NREQ'(1) << win_idx;
            ab_out   <= sel_addr[15:8];
            ab_phase <= 1'b1;
            state    <= ADDR_HI;
`ifdef BUS_RR_EN
            ptr      <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        ADDR_HI: begin
          ab_out   <= addr_q[7:0];
          ab_phase <= 1'b0;
          rw       <= ~we_q;
          state    <= ADDR_LO;
        end
        ADDR_LO: begin
          db_oe <= we_q;
          if (we_q) db_out <= wdata_q;
          state <= DATA;
        end
        DATA: begin
          // The cycle with rdy_in high wins even if it is also the last allowed wait.
          if (rdy_in || wcnt == WAIT_W'(WAIT_MAX - 1)) begin
            if (rdy_in && !we_q) rdata <= db_in;
            done  <= NREQ'(1) << gidx;
            err   <= ~rdy_in;
            gnt   <= '0;
            wcnt  <= '0;
            db_oe <= 1'b0;
            rw    <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
